seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential unsigned restoring divider. One quotient bit is resolved per
//   clock, MSB first, so a nonzero-divisor operation takes WIDTH cycles from
//   accept to result. A zero divisor skips the iterations and produces an
//   all-ones quotient, remainder = dividend and div_by_zero = 1 on the next
//   cycle.
//
//   Handshake: an operand pair is taken on an edge with in_valid && in_ready
//   (in_ready is high only while idle). The result is presented with
//   out_valid and held until an edge with out_ready = 1, after which the block
//   returns to idle; the next pair can be taken on the following edge.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand pair offered
//   in_ready     out  block can accept an operand pair (idle)
//   dividend     in   [WIDTH-1:0] unsigned dividend
//   divisor      in   [WIDTH-1:0] unsigned divisor
//   out_valid    out  result available
//   out_ready    in   consumer accepts the result
//   quotient     out  [WIDTH-1:0] unsigned quotient
//   remainder    out  [WIDTH-1:0] unsigned remainder
//   div_by_zero  out  result came from a zero divisor
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // One extra counter bit so the count reaches WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH:0]     prem_q;       // partial remainder
  logic [WIDTH-1:0]   quo_sh_q;     // dividend bits shift out, quotient bits shift in
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               dbz_q;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial_sum;
  logic               no_borrow;
  logic [WIDTH:0]     prem_d;
  logic [WIDTH-1:0]   quo_sh_d;

  // After every restore step the partial remainder is below the divisor, so
  // its top bit is always zero on entry to the next shift; it is only needed
  // for the shifted value, which can reach 2*divisor-1.
  logic               prem_msb_unused;
  assign prem_msb_unused = prem_q[WIDTH];

  // One restoring step: subtract via inverted divisor plus carry-in; the carry
  // out of the (WIDTH+1)-bit sum is the "no borrow" flag and the quotient bit.
  always_comb begin
    shifted   = {prem_q[WIDTH-1:0], quo_sh_q[WIDTH-1]};
    trial_sum = {1'b0, shifted}
              + {1'b0, ~{1'b0, divisor_q}}
              + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial_sum[WIDTH+1];
    prem_d    = no_borrow ? trial_sum[WIDTH:0] : shifted;
    quo_sh_d  = {quo_sh_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      prem_q      <= '0;
      quo_sh_q    <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            divisor_q <= divisor;
            quo_sh_q  <= dividend;
            prem_q    <= '0;
            cnt_q     <= '0;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          prem_q   <= prem_d;
          quo_sh_q <= quo_sh_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quotient_q  <= quo_sh_d;
            remainder_q <= prem_d[WIDTH-1:0];
            dbz_q       <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH = 64). Directed cases cover the
//   boundary results, zero divisor, result hold under backpressure and reset
//   during an operation; a randomized back-to-back run compares every result
//   and the accept-to-accept spacing against a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 64;
  localparam int CLK_P = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #(CLK_P/2) clk = ~clk;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference model: plain arithmetic on the definition of division.
  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] b);
    return (b == '0) ? 0 : WIDTH;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [WIDTH-1:0] rand_divisor();
    case ($urandom_range(0, 3))
      0:       return rand_word();
      1:       return {32'h0, $urandom};
      2:       return 64'($urandom_range(1, 255));
      default: return 64'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input int lat);
    check_val({tag, "_lat"}, 64'(lat), 64'(ref_lat(b)));
    check_val({tag, "_q"}, quotient, ref_q(a, b));
    check_val({tag, "_r"}, remainder, ref_r(a, b));
    check_val({tag, "_dbz"}, div_by_zero, (b == '0) ? 64'd1 : 64'd0);
    $display("op %s: %0h / %0h -> q=%0h r=%0h dbz=%0b lat=%0d",
             tag, a, b, quotient, remainder, div_by_zero, lat);
  endtask

  // Starts from IDLE, leaves the block in DONE with the result presented.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    int lat;
    check_val({tag, "_rdy"}, in_ready, 1);
    out_ready = 1'b0;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = rand_word();
    divisor   = rand_word();
    wait_result(lat);
    check_result(tag, a, b, lat);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_idle"}, in_ready, 1);
    check_val({tag, "_ovld"}, out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdy"}, in_ready, 1);
    check_val({tag, "_ovld"}, out_valid, 0);
    check_val({tag, "_q"}, quotient, 0);
    check_val({tag, "_r"}, remainder, 0);
    check_val({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] big;
    int               lat;
    int               gap_exp;
    int               seen_valid;
    longint           t_now;
    longint           t_prev;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(64'd100, 64'd7, "100div7");             release_result("100div7");
    run_op('1, 64'd1, "max_div1");                 release_result("max_div1");
    run_op(64'd5, 64'd9, "5div9");                 release_result("5div9");
    run_op(64'd1234, 64'd0, "div0");               release_result("div0");
    run_op(64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef, "equal");
    release_result("equal");
    run_op(64'd0, 64'd5, "zero_dvd");              release_result("zero_dvd");
    run_op('1, '1, "max_max");                     release_result("max_max");
    run_op('1, 64'h8000_0000_0000_0001, "big_dvs"); release_result("big_dvs");

    // Backpressure: result must hold while inputs churn
    run_op(64'd1000, 64'd3, "hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      dividend = rand_word();
      divisor  = rand_word();
      @(posedge clk); #1;
      check_val("hold_q", quotient, ref_q(64'd1000, 64'd3));
      check_val("hold_r", remainder, ref_r(64'd1000, 64'd3));
      check_val("hold_dbz", div_by_zero, 0);
      check_val("hold_rdy", in_ready, 0);
      check_val("hold_ovld", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result("hold");

    // Reset during iteration 30 of 2^63/3
    big      = 64'h8000_0000_0000_0000;
    dividend = big;
    divisor  = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen_valid++;
    end
    check_val("midrst_noresult", 64'(seen_valid), 0);
    run_op(64'd9, 64'd3, "after_rst");
    release_result("after_rst");

    // Back-to-back random operations with out_ready held high
    a         = rand_word();
    b         = rand_divisor();
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    t_prev    = 0;
    gap_exp   = 0;
    check_val("b2b_rdy", in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;                       // accept edge
      t_now = longint'($time);
      if (i > 0) check_val("b2b_gap", 64'((t_now - t_prev) / CLK_P), 64'(gap_exp));
      t_prev  = t_now;
      ea      = dividend;
      eb      = divisor;
      gap_exp = ref_lat(eb) + 2;
      check_val("b2b_taken", in_ready, 0);
      if (i < 15) begin
        dividend = rand_word();
        divisor  = rand_divisor();
      end else begin
        in_valid = 1'b0;
      end
      wait_result(lat);
      check_result($sformatf("b2b%0d", i), ea, eb, lat);
      @(posedge clk); #1;                       // DONE -> IDLE
    end
    out_ready = 1'b0;
    check_val("b2b_end_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
